// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the EX stage.
//   ALU_*   : 4-bit ALU operation codes driven on alu_sel
//   MD_*    : 3-bit M-extension codes (RV funct3 order) driven on md_op
//   FWD_*   : forwarding-mux select codes (2'b11 is reserved, behaves as FWD_REG)
//   md_state_t : multiply/divide sequencer states
// Helper functions tell which M-op operands are treated as signed.
package ex_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_PASSB = 4'd9;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEM   = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV and REM.
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV M-extension unit, one result bit per cycle.
//   cpu_clk, cpu_rst : clock, synchronous active-high reset
//   start            : accept an M-op (only honoured in IDLE)
//   flush            : abort whatever is in progress, return to IDLE
//   op               : MD_* operation code
//   src_a, src_b     : forwarded rs1 / rs2
//   idle, busy, done : current sequencer state
//   result           : result register, meaningful while done = 1
// Optional feature macro: EX_MD_DIV_EN builds the restoring divider; when
// undefined, divide ops complete in one stall cycle with result 0.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            idle,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    md_state_t         state;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   result_q;

    logic              a_neg;
    logic              b_neg;
    logic              neg_start;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   final_res;

    // Operands are reduced to magnitudes; the sign is reapplied at the end.
    // A remainder takes the dividend's sign, everything else the xor.
    always_comb begin
        a_neg     = md_a_signed(op) & src_a[XLEN-1];
        b_neg     = md_b_signed(op) & src_b[XLEN-1];
        abs_a     = a_neg ? -src_a : src_a;
        abs_b     = b_neg ? -src_b : src_b;
        neg_start = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef EX_MD_DIV_EN
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   div_rem;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    // Divide-by-zero and MIN / -1 are resolved without iterating.
    always_comb begin
        div_zero = (src_b == '0);
        div_ovf  = ~op[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
        if (div_zero) begin
            special_res = op[1] ? src_a : '1;
        end else begin
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end
`endif

    // One iteration. Multiply: shift-add with the multiplier in acc_lo and
    // the partial product growing into acc_hi. Divide: restoring step with
    // the remainder in acc_hi and quotient bits shifting into acc_lo.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        hi_next = mul_sum[XLEN:1];
        lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef EX_MD_DIV_EN
        div_rem  = {acc_hi, acc_lo[XLEN-1]};
        div_ge   = (div_rem >= {1'b0, opnd_q});
        div_diff = div_rem[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            hi_next = div_ge ? div_diff : div_rem[XLEN-1:0];
            lo_next = {acc_lo[XLEN-2:0], div_ge};
        end
`endif
    end

    // The product sign must be applied across the full 2*XLEN width
    // before picking a half.
    always_comb begin
        prod      = {hi_next, lo_next};
        prod_s    = neg_q ? -prod : prod;
        final_res = (op_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef EX_MD_DIV_EN
        if (op_q[2]) begin
            if (op_q[1]) begin
                final_res = neg_q ? -hi_next : hi_next;
            end else begin
                final_res = neg_q ? -lo_next : lo_next;
            end
        end
`endif
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= neg_start;
                        opnd_q <= op[2] ? abs_b : abs_a;
                        acc_hi <= '0;
                        acc_lo <= op[2] ? abs_a : abs_b;
                        count  <= CW'(XLEN);
                        state  <= BUSY;
                        if (op[2]) begin
`ifdef EX_MD_DIV_EN
                            if (div_zero || div_ovf) begin
                                result_q <= special_res;
                                count    <= '0;
                                state    <= DONE;
                            end
`else
                            result_q <= '0;
                            count    <= '0;
                            state    <= DONE;
`endif
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= hi_next;
                    acc_lo <= lo_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign idle   = (state == IDLE);
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: rtl/ex_unit_md.sv
// ex_unit_md: execute stage with operand forwarding, single-cycle ALU and
// comparator, and an iterative multiply/divide unit that stalls the pipe.
//   cpu_clk, cpu_rst            : clock, synchronous active-high reset
//   in_valid, flush             : EX instruction valid / kill
//   rd1, rd2, imm, pc           : register operands, immediate, PC
//   rd1_pc_sel, rd2_imm_sel     : ALU A/B source selects
//   alu_sel, unsigned_sel       : ALU op, unsigned compare
//   md_en, md_op                : M-op enable and code
//   fwd_a_sel, fwd_b_sel        : forwarding selects (reg / MEM / WB)
//   fwd_mem_data, fwd_wb_data   : forwarded results
//   comp_out                    : {eq, lt} of forwarded rs1 vs rs2
//   alu_out, out_valid          : result and its valid
//   ex_stall                    : hold IF/ID/EX, bubble EX/MEM
// Optional feature macro: EX_MD_DIV_EN (divider, see ex_muldiv).
module ex_unit_md
    import ex_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            rd1_pc_sel,
    input  logic            rd2_imm_sel,
    input  logic [3:0]      alu_sel,
    input  logic            unsigned_sel,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic [1:0]      comp_out,
    output logic [XLEN-1:0] alu_out,
    output logic            out_valid,
    output logic            ex_stall
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] md_result;
    logic [SHW-1:0]  shamt;
    logic            lt_fwd;
    logic            lt_alu;
    logic            md_start;
    logic            md_idle;
    logic            md_busy;
    logic            md_done;

    // Reserved select 2'b11 falls through to the register-file value.
    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: fwd_a = fwd_mem_data;
            FWD_WB:  fwd_a = fwd_wb_data;
            default: fwd_a = rd1;
        endcase
        case (fwd_b_sel)
            FWD_MEM: fwd_b = fwd_mem_data;
            FWD_WB:  fwd_b = fwd_wb_data;
            default: fwd_b = rd2;
        endcase
    end

    always_comb begin
        alu_a  = rd1_pc_sel  ? pc  : fwd_a;
        alu_b  = rd2_imm_sel ? imm : fwd_b;
        shamt  = alu_b[SHW-1:0];
        lt_fwd = unsigned_sel ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));
        lt_alu = unsigned_sel ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
    end

    always_comb begin
        case (alu_sel)
            ALU_ADD:   alu_res = alu_a + alu_b;
            ALU_SUB:   alu_res = alu_a - alu_b;
            ALU_AND:   alu_res = alu_a & alu_b;
            ALU_OR:    alu_res = alu_a | alu_b;
            ALU_XOR:   alu_res = alu_a ^ alu_b;
            ALU_SLL:   alu_res = alu_a << shamt;
            ALU_SRL:   alu_res = alu_a >> shamt;
            ALU_SRA:   alu_res = $signed(alu_a) >>> shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_alu};
            ALU_PASSB: alu_res = alu_b;
            default:   alu_res = '0;
        endcase
    end

    assign md_start = in_valid & md_en & ~flush;

    ex_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .start   (md_start),
        .flush   (flush),
        .op      (md_op),
        .src_a   (fwd_a),
        .src_b   (fwd_b),
        .idle    (md_idle),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_result)
    );

    // The accept cycle already stalls; the DONE cycle releases the pipe
    // and presents the registered M-op result.
    always_comb begin
        comp_out  = {fwd_a == fwd_b, lt_fwd};
        alu_out   = md_done ? md_result : alu_res;
        ex_stall  = ~cpu_rst & ~flush & (md_busy | (md_idle & md_start));
        out_valid = ~cpu_rst & ~flush & (md_done | (md_idle & in_valid & ~md_en));
    end

endmodule

// File: tb/tb_ex_unit_md.sv
`timescale 1ns/1ps
module tb_ex_unit_md;
    import ex_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        in_valid, flush, rd1_pc_sel, rd2_imm_sel, unsigned_sel, md_en;
    logic [31:0] rd1, rd2, imm, pc, fwd_mem_data, fwd_wb_data;
    logic [3:0]  alu_sel;
    logic [2:0]  md_op;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [1:0]  comp_out;
    logic [31:0] alu_out;
    logic        out_valid, ex_stall;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    ex_unit_md #(.XLEN(XLEN)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .flush(flush),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc),
        .rd1_pc_sel(rd1_pc_sel), .rd2_imm_sel(rd2_imm_sel),
        .alu_sel(alu_sel), .unsigned_sel(unsigned_sel),
        .md_en(md_en), .md_op(md_op),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .comp_out(comp_out), .alu_out(alu_out),
        .out_valid(out_valid), .ex_stall(ex_stall)
    );

    // Reference ALU from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic uns);
        logic [31:0] sh;
        sh = b % 32;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return $signed(a) >>> sh;
            ALU_SLT:   return uns ? {31'b0, a < b} : {31'b0, $signed(a) < $signed(b)};
            ALU_PASSB: return b;
            default:   return 32'h0;
        endcase
    endfunction

    // Reference M-extension result using 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            MD_MUL:    begin p = sa * sb;           return p[31:0];  end
            MD_MULH:   begin p = sa * sb;           return p[63:32]; end
            MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MD_MULHU:  begin p = ua * ub;           return p[63:32]; end
`ifdef EX_MD_DIV_EN
            MD_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            MD_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            MD_REM:    begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
            MD_REMU:   begin if (b == 0) return a;             p = ua % ub; return p[31:0]; end
`endif
            default:   return 32'h0;
        endcase
    endfunction

    // Number of cycles ex_stall should be high for an accepted M-op.
    function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op >= MD_DIV) begin
`ifdef EX_MD_DIV_EN
            if (b == 0) return 1;
            if ((op == MD_DIV || op == MD_REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
`else
            return 1;
`endif
        end
        return XLEN + 1;
    endfunction

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; rd1_pc_sel = 0; rd2_imm_sel = 0; unsigned_sel = 0;
        md_en = 0; md_op = 0; alu_sel = ALU_ADD; fwd_a_sel = 0; fwd_b_sel = 0;
        rd1 = 0; rd2 = 0; imm = 0; pc = 0; fwd_mem_data = 0; fwd_wb_data = 0;
    endtask

    // Issue one M-op (operands sometimes via forwarding) and follow it to DONE.
    task automatic run_mop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_stalls, input string name);
        int stalls;
        bit timed_out;
        bit bad_valid;
        idle_inputs();
        in_valid = 1; md_en = 1; md_op = op;
        fwd_a_sel = 2'($urandom_range(0, 3));
        fwd_b_sel = 2'($urandom_range(0, 3));
        rd1 = $urandom; rd2 = $urandom; fwd_mem_data = $urandom; fwd_wb_data = $urandom;
        if (fwd_a_sel == FWD_MEM) fwd_mem_data = a; else if (fwd_a_sel == FWD_WB) fwd_wb_data = a; else rd1 = a;
        if (fwd_b_sel == FWD_MEM) begin
            if (fwd_a_sel == FWD_MEM) fwd_b_sel = FWD_REG; else fwd_mem_data = b;
        end else if (fwd_b_sel == FWD_WB) begin
            if (fwd_a_sel == FWD_WB) fwd_b_sel = FWD_REG; else fwd_wb_data = b;
        end
        if (fwd_b_sel == FWD_REG || fwd_b_sel == 2'b11) rd2 = b;
        stalls = 0; timed_out = 1; bad_valid = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge cpu_clk);
            if (!ex_stall) begin
                timed_out = 0;
                break;
            end
            stalls++;
            if (out_valid) bad_valid = 1;
            step();
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("[TB] FAIL %s timeout: ex_stall still high after 100 cycles, expected release", name);
        end else begin
            if (stalls !== exp_stalls) begin
                errors++;
                $display("[TB] FAIL %s stall count: got %0d expected %0d", name, stalls, exp_stalls);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s out_valid in DONE: got %b expected 1", name, out_valid);
            end
            checks++;
            if (alu_out !== exp_res) begin
                errors++;
                $display("[TB] FAIL %s result op=%0d a=%h b=%h: got %h expected %h", name, op, a, b, alu_out, exp_res);
            end
            checks++;
            if (bad_valid) begin
                errors++;
                $display("[TB] FAIL %s out_valid during stall: got 1 expected 0", name);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        cpu_rst = 1; in_valid = 1; rd1 = 3; rd2 = 4;
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
        md_en = 1;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset ex_stall: got %b expected 0", ex_stall); end
        step(); step();
        cpu_rst = 0;
        idle_inputs();
        step();
    endtask

    task automatic test_forwarding();
        logic [31:0] a, b, fa, fb, exp;
        idle_inputs();
        in_valid = 1; alu_sel = ALU_ADD; fwd_a_sel = FWD_MEM; fwd_b_sel = FWD_WB;
        fwd_mem_data = 5; fwd_wb_data = 7;
        @(negedge cpu_clk);
        checks++;
        if (alu_out !== 32'd12 || out_valid !== 1'b1 || ex_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwd add: got out=%h v=%b s=%b expected out=0000000c v=1 s=0", alu_out, out_valid, ex_stall);
        end
        step();
        for (int i = 0; i < 30; i++) begin
            rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom;
            fwd_mem_data = $urandom; fwd_wb_data = $urandom;
            if (i % 3 == 0) rd2 = $urandom_range(0, 70);
            fwd_a_sel = 2'($urandom_range(0, 3)); fwd_b_sel = 2'($urandom_range(0, 3));
            rd1_pc_sel = 1'($urandom_range(0, 1)); rd2_imm_sel = 1'($urandom_range(0, 1));
            unsigned_sel = 1'($urandom_range(0, 1));
            alu_sel = 4'($urandom_range(0, 9));
            fa = (fwd_a_sel == FWD_MEM) ? fwd_mem_data : (fwd_a_sel == FWD_WB) ? fwd_wb_data : rd1;
            fb = (fwd_b_sel == FWD_MEM) ? fwd_mem_data : (fwd_b_sel == FWD_WB) ? fwd_wb_data : rd2;
            a = rd1_pc_sel ? pc : fa;
            b = rd2_imm_sel ? imm : fb;
            exp = ref_alu(alu_sel, a, b, unsigned_sel);
            @(negedge cpu_clk);
            checks++;
            if (alu_out !== exp) begin
                errors++;
                $display("[TB] FAIL alu op=%0d a=%h b=%h: got %h expected %h", alu_sel, a, b, alu_out, exp);
            end
            checks++;
            if (comp_out !== {fa == fb, unsigned_sel ? fa < fb : $signed(fa) < $signed(fb)}) begin
                errors++;
                $display("[TB] FAIL comp_out a=%h b=%h u=%b: got %b", fa, fb, unsigned_sel, comp_out);
            end
            checks++;
            if (out_valid !== 1'b1 || ex_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL alu handshake: got v=%b s=%b expected v=1 s=0", out_valid, ex_stall);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_compare();
        idle_inputs();
        in_valid = 1; rd1 = 32'hFFFF_FFFF; rd2 = 1; unsigned_sel = 0;
        @(negedge cpu_clk);
        checks++;
        if (comp_out !== 2'b01) begin errors++; $display("[TB] FAIL comp signed: got %b expected 01", comp_out); end
        unsigned_sel = 1;
        #1;
        checks++;
        if (comp_out !== 2'b00) begin errors++; $display("[TB] FAIL comp unsigned: got %b expected 00", comp_out); end
        alu_sel = ALU_SRA; rd1 = 32'h8000_0000; rd2 = 33;
        #1;
        checks++;
        if (alu_out !== 32'hC000_0000) begin errors++; $display("[TB] FAIL sra by 33: got %h expected c0000000", alu_out); end
        step();
        idle_inputs();
    endtask

    task automatic test_flush_alu();
        idle_inputs();
        in_valid = 1; flush = 1; rd1 = 9; rd2 = 9;
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush alu out_valid: got %b expected 0", out_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        logic [2:0]  op;
        run_mop(MD_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, "mulh -2*3");
        run_mop(MD_MUL,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33, "mul -2*3");
        run_mop(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu max");
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            if (i == 0) a = MIN32;
            run_mop(op, a, b, ref_md(op, a, b), ref_stalls(op, a, b), "mul rand");
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        logic [2:0]  op;
`ifdef EX_MD_DIV_EN
        run_mop(MD_DIV,  32'd7, 32'd0, 32'hFFFF_FFFF, 1, "div by 0");
        run_mop(MD_REM,  32'd7, 32'd0, 32'd7, 1, "rem by 0");
        run_mop(MD_DIV,  MIN32, 32'hFFFF_FFFF, MIN32, 1, "div overflow");
        run_mop(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu 100/7");
        run_mop(MD_REMU, 32'd100, 32'd7, 32'd2, 33, "remu 100/7");
`else
        run_mop(MD_DIV,  32'd7, 32'd0, 32'd0, 1, "div by 0");
        run_mop(MD_REM,  32'd7, 32'd0, 32'd0, 1, "rem by 0");
        run_mop(MD_DIV,  MIN32, 32'hFFFF_FFFF, 32'd0, 1, "div overflow");
        run_mop(MD_DIVU, 32'd100, 32'd7, 32'd0, 1, "divu 100/7");
        run_mop(MD_REMU, 32'd100, 32'd7, 32'd0, 1, "remu 100/7");
`endif
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(4, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = MIN32; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 20);
                3: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run_mop(op, a, b, ref_md(op, a, b), ref_stalls(op, a, b), "div rand");
        end
    endtask

    task automatic test_flush_busy();
        idle_inputs();
        in_valid = 1; md_en = 1; md_op = MD_MULHU; rd1 = $urandom; rd2 = $urandom;
        for (int c = 0; c < 10; c++) step();
        flush = 1;
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush busy out_valid: got %b expected 0", out_valid); end
        step();
        idle_inputs();
        in_valid = 1; rd1 = 20; rd2 = 22;
        @(negedge cpu_clk);
        checks++;
        if (ex_stall !== 1'b0 || out_valid !== 1'b1 || alu_out !== 32'd42) begin
            errors++;
            $display("[TB] FAIL add after flush: got s=%b v=%b out=%h expected s=0 v=1 out=0000002a", ex_stall, out_valid, alu_out);
        end
        step();
        run_mop(MD_MUL, 32'd6, 32'd7, 32'd42, 33, "mul after flush");
    endtask

    task automatic test_reset_busy();
        idle_inputs();
        in_valid = 1; md_en = 1; md_op = MD_MUL; rd1 = 11; rd2 = 13;
        for (int c = 0; c < 5; c++) step();
        cpu_rst = 1;
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0 || ex_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in reset: got v=%b s=%b expected v=0 s=0", out_valid, ex_stall);
        end
        step();
        cpu_rst = 0;
        idle_inputs();
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0 || ex_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after reset abort: got v=%b s=%b expected v=0 s=0", out_valid, ex_stall);
        end
        step();
        run_mop(MD_MUL, 32'd11, 32'd13, 32'd143, 33, "mul after reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < 4; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            run_mop(op, a, b, ref_md(op, a, b), ref_stalls(op, a, b), "back to back");
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forwarding();
        test_compare();
        test_flush_alu();
        test_mul();
        test_div();
        test_flush_busy();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
